// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, flag-class decode and datapath defaults.
package cpu_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefRegAw = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // ADD/SUB write Z, V and N.
  function automatic logic updates_all_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // XOR and the shifters write Z only.
  function automatic logic updates_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural Z/V/N flag register with opcode-class update decode.
module flag_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_en,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovfl,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic z_q, v_q, n_q;
  logic z_d, v_d, n_d;

  // Next-state: flags written per opcode class only when enabled.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (upd_en) begin
      if (updates_all_flags(opcode)) begin
        z_d = ~|result;
        v_d = ovfl;
        n_d = result[DATA_W-1];
      end else if (updates_z_only(opcode)) begin
        z_d = ~|result;
      end
    end
  end

  // Flag state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

  assign flag_z = z_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with stall/flush control and the flag register.
module ex_mem_stage_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_halt,
  output logic              mem_valid,
  output logic [3:0]        mem_opcode,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_halt,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic              valid_q;
  logic [3:0]        opcode_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] store_data_q;
  logic [REG_AW-1:0] rd_q;
  logic              regwrite_q, memread_q, memwrite_q, halt_q;
  logic              load;
  logic              flag_upd;

  assign load     = !flush && !stall;
  assign flag_upd = load && ex_valid;

  // Pipeline register: reset > flush > stall > load. Flush leaves data fields stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      opcode_q     <= '0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      halt_q       <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      halt_q     <= 1'b0;
    end else if (load) begin
      valid_q      <= ex_valid;
      opcode_q     <= ex_opcode;
      result_q     <= ex_result;
      store_data_q <= ex_store_data;
      rd_q         <= ex_rd;
      regwrite_q   <= ex_regwrite & ex_valid;
      memread_q    <= ex_memread & ex_valid;
      memwrite_q   <= ex_memwrite & ex_valid;
      halt_q       <= ex_halt & ex_valid;
    end
  end

  flag_reg #(
    .DATA_W (DATA_W)
  ) u_flag_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd_en (flag_upd),
    .opcode (ex_opcode),
    .result (ex_result),
    .ovfl   (ex_ovfl),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

  assign mem_valid      = valid_q;
  assign mem_opcode     = opcode_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_data_q;
  assign mem_rd         = rd_q;
  assign mem_regwrite   = regwrite_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign mem_halt       = halt_q;

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Pipeline register between Execute and Memory; captures the execute result (ALU or shifter output), store data, destination register and control bits for the Memory stage.
- Also owns the architectural flag register (Z, V, N); flags update when an instruction leaves Execute, according to its opcode class.
- Supports pipeline hold (stall) and bubble insertion (flush) from the hazard unit.

Parameters:
- DATA_W, 16, datapath width for result and store data
- REG_AW, 4, register-file address width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hold all state (pipeline register and flags)
- flush  in  1  capture a bubble (valid=0) instead of the EX instruction
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  EX instruction opcode
- ex_result  in  DATA_W  ALU/shifter/LLB/LHB/PCS result (already saturated for ADD/SUB)
- ex_ovfl  in  1  signed overflow from ADD/SUB adder, pre-saturation
- ex_store_data  in  DATA_W  forwarded rt value for SW
- ex_rd  in  REG_AW  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_halt  in  1 each  control bits
- mem_valid  out  1  registered valid
- mem_opcode  out  4  registered opcode
- mem_result  out  DATA_W  registered result / memory address
- mem_store_data  out  DATA_W  registered store data
- mem_rd  out  REG_AW  registered destination
- mem_regwrite, mem_memread, mem_memwrite, mem_halt  out  1 each  registered controls, forced 0 when mem_valid=0
- flag_z, flag_v, flag_n  out  1 each  architectural flags, read by branch logic

Behaviour:
- Priority per edge: reset > flush > stall > load.
- Reset (rst_n=0 at edge): all outputs 0, including every flag.
- Flush: mem_valid=0; all mem_* controls=0; data fields may hold old values; flags unchanged. Flush overrides a simultaneous stall.
- Stall without flush: every register, including the flags, holds its value.
- Load (neither stall nor flush): all mem_* fields take the ex_* values. Controls are ANDed with ex_valid, so an invalid EX gives zero controls.
- Latency: one cycle from ex_* to mem_*; no combinational path from input to output.
- Flag update happens only on a load edge with ex_valid=1. It uses the same edge as the capture, so flags are visible the cycle after the instruction leaves EX.
  - ADD(0000), SUB(0001): Z=(ex_result==0), V=ex_ovfl, N=ex_result[15].
  - XOR(0010), SLL(0100), SRA(0101), ROR(0110): Z=(ex_result==0); V and N held.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): flags held.
- Z is computed on the saturated result. Example: ADD saturating to 0x7FFF gives Z=0, V=1, N=0.
- mem_halt stays set only while the instruction occupies the stage; it is not sticky in this block.
- Reset asserted mid-stall clears everything; stall does not block reset.

Decomposition:
- Shared package (cpu_pkg): 4-bit opcode constants (OP_ADD … OP_HLT), the flag-class function (updates_all_flags, updates_z_only), DATA_W and REG_AW defaults. The Execute and Decode stages reuse the same package.
- One sub-module: flag_reg. It takes opcode, result, ovfl and update-enable, holds Z/V/N, and owns the class decode. The top level is the pipeline register plus the enable logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs and stall=1 -> all outputs 0, flags 000; first valid load after release propagates next cycle.
- ADD overflow: ex_opcode=0000, ex_result=0x7FFF, ex_ovfl=1, valid -> next cycle mem_result=0x7FFF, Z=0, V=1, N=0. Then SUB with ex_result=0x0000, ovfl=0 -> Z=1, V=0, N=0.
- Shift Z-only: start with V=1, N=1. SLL with ex_result=0x0000 -> Z=1, V=1, N=1 unchanged. Then ROR with ex_result=0x8001 -> Z=0, V and N still 1.
- Stall hold: load LW (rd=5, memread=1, result=0x0040), then stall=1 for 3 cycles while ex_* changes and ex_opcode=ADD -> mem_* and flags constant; the new ADD captured on the first edge after stall drops.
- Flush priority: stall=1 and flush=1 together with EX holding SW (memwrite=1) -> next cycle mem_valid=0, mem_memwrite=0, flags unchanged.
- Invalid / no-flag ops: ex_valid=0 with opcode=ADD, result=0 -> flags unchanged, controls 0. LLB valid with result=0 -> flags unchanged, mem_regwrite=1.
